// File: rtl/bram_dma_pkg.sv
// Shared types and widths for the BRAM DMA copier and its bench.
package bram_dma_pkg;

  localparam int DMA_ADDR_W = 16;
  localparam int DMA_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_REL     = 3'd4,
    S_FIN     = 3'd5
  } state_t;

endpackage

// File: rtl/bram_dma_copier_if.sv
// Initiator-side port of the 64KB BRAM responder.
interface bram_dma_copier_if;
  import bram_dma_pkg::*;

  // Handshake: the initiator holds mem_cs (mem_we=0) with a stable mem_addr until the
  // responder raises mem_dr alongside valid mem_din; dropping mem_cs clears mem_dr.
  // A write is a single cycle of mem_cs=1, mem_we=1 with mem_addr/mem_dout valid.
  logic                  mem_cs;
  logic                  mem_we;
  logic [DMA_ADDR_W-1:0] mem_addr;
  logic [DMA_DATA_W-1:0] mem_dout;
  logic [DMA_DATA_W-1:0] mem_din;
  logic                  mem_dr;

  modport master (
    output mem_cs, mem_we, mem_addr, mem_dout,
    input  mem_din, mem_dr
  );

  modport slave (
    input  mem_cs, mem_we, mem_addr, mem_dout,
    output mem_din, mem_dr
  );

endinterface

// File: rtl/bram_dma_copier.sv
// Byte-wise BRAM copier: read, write, release per byte with a read timeout abort.
// Defining BRAM_DMA_FILL_EN adds fill/fill_val for a write-only constant fill mode.
module bram_dma_copier
  import bram_dma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DMA_ADDR_W-1:0] src_addr,
  input  logic [DMA_ADDR_W-1:0] dst_addr,
  input  logic [DMA_ADDR_W-1:0] len,
  input  logic                  start,
`ifdef BRAM_DMA_FILL_EN
  input  logic                  fill,
  input  logic [DMA_DATA_W-1:0] fill_val,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output state_t                dbg_state,
  bram_dma_copier_if.master     mem
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state_q, state_d;
  logic [DMA_ADDR_W-1:0] src_q, src_d;
  logic [DMA_ADDR_W-1:0] dst_q, dst_d;
  logic [DMA_ADDR_W-1:0] rem_q, rem_d;
  logic [DMA_DATA_W-1:0] data_q, data_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  err_q, err_d;
`ifdef BRAM_DMA_FILL_EN
  logic                  fill_q, fill_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
`ifdef BRAM_DMA_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
`ifdef BRAM_DMA_FILL_EN
      fill_q  <= fill_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    wait_d  = wait_q;
    err_d   = err_q;
`ifdef BRAM_DMA_FILL_EN
    fill_d  = fill_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          rem_d  = len;
          wait_d = '0;
          err_d  = 1'b0;
`ifdef BRAM_DMA_FILL_EN
          fill_d = fill;
          data_d = fill ? fill_val : data_q;
          if (len == '0)  state_d = S_FIN;
          else if (fill)  state_d = S_WR;
          else            state_d = S_RD_REQ;
`else
          state_d = (len == '0) ? S_FIN : S_RD_REQ;
`endif
        end
      end
      S_RD_REQ: begin
        wait_d  = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem.mem_dr) begin
          data_d  = mem.mem_din;
          state_d = S_WR;
        end else begin
          wait_d = wait_q + 1'b1;
          // Abort without writing: the byte never arrived.
          if (wait_d == WAIT_W'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_WR: state_d = S_REL;
      S_REL: begin
        src_d = src_q + 1'b1;
        dst_d = dst_q + 1'b1;
        rem_d = rem_q - 1'b1;
        if (rem_q == DMA_ADDR_W'(1)) state_d = S_FIN;
`ifdef BRAM_DMA_FILL_EN
        else if (fill_q)             state_d = S_WR;
`endif
        else                         state_d = S_RD_REQ;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from state alone, so an async reset clears them immediately.
  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_FIN);
    err          = err_q;
    dbg_state    = state_q;
    mem.mem_cs   = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_addr = '0;
    mem.mem_dout = '0;
    unique case (state_q)
      S_RD_REQ, S_RD_WAIT: begin
        mem.mem_cs   = 1'b1;
        mem.mem_addr = src_q;
      end
      S_WR: begin
        mem.mem_cs   = 1'b1;
        mem.mem_we   = 1'b1;
        mem.mem_addr = dst_q;
        mem.mem_dout = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bram_dma_copier.sv
// Randomized scoreboard bench for bram_dma_copier with a behavioural BRAM responder.
`timescale 1ns/1ps
module tb_bram_dma_copier;
  import bram_dma_pkg::*;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        start = 1'b0;
`ifdef BRAM_DMA_FILL_EN
  logic        fill = 1'b0;
  logic [7:0]  fill_val = '0;
`endif
  logic        busy, done, err;
  state_t      dbg_state;

  bram_dma_copier_if mem_if ();

  bram_dma_copier #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .start    (start),
`ifdef BRAM_DMA_FILL_EN
    .fill     (fill),
    .fill_val (fill_val),
`endif
    .busy     (busy),
    .done     (done),
    .err      (err),
    .dbg_state(dbg_state),
    .mem      (mem_if.master)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- BRAM responder (one-cycle read latency) ----------------
  logic [7:0]  mem [0:65535];
  logic        stall = 1'b0;
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_if.mem_dr  <= 1'b0;
      mem_if.mem_din <= '0;
    end else begin
      if (pre_en) mem[pre_addr] <= pre_data;
      if (!mem_if.mem_cs) mem_if.mem_dr <= 1'b0;
      else if (mem_if.mem_we) mem[mem_if.mem_addr] <= mem_if.mem_dout;
      else if (!stall) begin
        mem_if.mem_din <= mem[mem_if.mem_addr];
        mem_if.mem_dr  <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          wr_seen = 0;
  int          done_cnt = 0;
  logic [23:0] exp_q[$];        // {addr, data} of each expected write, in order
  logic [15:0] rd_q[$];         // expected read addresses, in order
  int          exp_done_q[$];   // absolute cycle at which done must appear
  logic        exp_err_q[$];
  logic [7:0]  shadow [0:65535];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic        prev_cs;
    logic        prev_we;
    logic [23:0] e;
    prev_cs = 1'b0;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cs = 1'b0;
        prev_we = 1'b0;
      end else begin
        if (mem_if.mem_cs && mem_if.mem_we) begin
          wr_seen++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr %0h data %0h", mem_if.mem_addr, mem_if.mem_dout);
          end else begin
            e = exp_q.pop_front();
            check("write", {8'h0, mem_if.mem_addr, mem_if.mem_dout}, {8'h0, e});
          end
        end
        if (mem_if.mem_cs && !mem_if.mem_we && prev_cs && prev_we) begin
          checks++; errors++;
          $display("FAIL cs_gap: read at %0h follows write without release", mem_if.mem_addr);
        end
        if (mem_if.mem_cs && !mem_if.mem_we && !prev_cs) begin
          if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read: addr %0h", mem_if.mem_addr);
          end else begin
            check("read_addr", {16'h0, mem_if.mem_addr}, {16'h0, rd_q.pop_front()});
          end
        end
        if (done) begin
          done_cnt++;
          if (exp_done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: cycle %0d", cyc);
          end else begin
            check("done_cycle", cyc, exp_done_q.pop_front());
            check("done_err", {31'h0, err}, {31'h0, exp_err_q.pop_front()});
            check("writes_left", exp_q.size(), 0);
            check("reads_left", rd_q.size(), 0);
          end
        end
        prev_cs = mem_if.mem_cs;
        prev_we = mem_if.mem_we;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    shadow[a] = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Reference model: ascending byte copy (later reads see earlier writes), or a
  // constant fill, or a single read that never completes when the responder stalls.
  task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                       input bit f, input logic [7:0] fv, input bit stl);
    logic [15:0] a, b;
    int lat;
    if (n != 0) begin
      if (f) begin
        for (int i = 0; i < int'(n); i++) begin
          b = d + 16'(i);
          shadow[b] = fv;
          exp_q.push_back({b, fv});
        end
      end else if (stl) begin
        rd_q.push_back(s);
      end else begin
        for (int i = 0; i < int'(n); i++) begin
          a = s + 16'(i);
          b = d + 16'(i);
          rd_q.push_back(a);
          shadow[b] = shadow[a];
          exp_q.push_back({b, shadow[a]});
        end
      end
    end
    if (n == 0)   lat = 2;
    else if (stl) lat = 3 + TIMEOUT;
    else if (f)   lat = 2 * int'(n) + 2;
    else          lat = 4 * int'(n) + 2;
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = n;
    stall    = stl;
`ifdef BRAM_DMA_FILL_EN
    fill     = f;
    fill_val = fv;
`endif
    start    = 1'b1;
    exp_done_q.push_back(cyc + lat - 1);
    exp_err_q.push_back(stl && (n != 0));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound);
    int k;
    k = 0;
    while (done_cnt < target && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < target) begin
      checks++; errors++;
      $display("FAIL done_timeout: done count %0d expected %0d", done_cnt, target);
    end
    @(negedge clk);
    stall = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_cs"},   {31'h0, mem_if.mem_cs}, 32'h0);
    check({tag, "_we"},   {31'h0, mem_if.mem_we}, 32'h0);
    check({tag, "_addr"}, {16'h0, mem_if.mem_addr}, 32'h0);
    check({tag, "_dout"}, {24'h0, mem_if.mem_dout}, 32'h0);
    check({tag, "_state"}, {29'h0, dbg_state}, {29'h0, S_IDLE});
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [15:0] s, d, n;
    int t, base;
    logic [7:0] init_pat [0:3];
    init_pat[0] = 8'h11; init_pat[1] = 8'h22; init_pat[2] = 8'h33; init_pat[3] = 8'h44;

    #1;
    check_idle_outputs("reset");
    check("reset_err", {31'h0, err}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Known 4-byte copy
    for (int i = 0; i < 4; i++) preload(16'h1000 + 16'(i), init_pat[i]);
    t = done_cnt + 1;
    issue(16'h1000, 16'h2000, 16'd4, 1'b0, 8'h0, 1'b0);
    check("busy_during", {31'h0, busy}, 32'h1);
    wait_done(t, 60);
    for (int i = 0; i < 4; i++) check("copy_mem", {24'h0, mem[16'h2000 + 16'(i)]}, {24'h0, init_pat[i]});
    check("idle_busy", {31'h0, busy}, 32'h0);

    // Source wraps FFFF -> 0000
    preload(16'hFFFE, 8'hA1); preload(16'hFFFF, 8'hB2); preload(16'h0000, 8'hC3);
    t = done_cnt + 1;
    issue(16'hFFFE, 16'h0100, 16'd3, 1'b0, 8'h0, 1'b0);
    wait_done(t, 60);

    // Zero length: no memory traffic
    t = done_cnt + 1;
    issue(16'h1234, 16'h5678, 16'd0, 1'b0, 8'h0, 1'b0);
    wait_done(t, 20);

    // Responder never answers: timeout abort, err persists
    preload(16'h0700, 8'h5A);
    t = done_cnt + 1;
    issue(16'h0700, 16'h0800, 16'd3, 1'b0, 8'h0, 1'b1);
    wait_done(t, 40);
    repeat (3) @(negedge clk);
    check("err_persist", {31'h0, err}, 32'h1);

    // Reset during the write of byte 2 of 4, then a clean restart
    for (int i = 0; i < 4; i++) preload(16'h4000 + 16'(i), 8'($urandom_range(0, 255)));
    base = wr_seen;
    issue(16'h4000, 16'h5000, 16'd4, 1'b0, 8'h0, 1'b0);
    begin : find_wr2
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (mem_if.mem_cs && mem_if.mem_we && wr_seen == base + 1) disable find_wr2;
      end
    end
    check("wr2_reached", {31'h0, (mem_if.mem_cs && mem_if.mem_we)}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    check("midreset_err", {31'h0, err}, 32'h0);
    exp_q.delete(); rd_q.delete(); exp_done_q.delete(); exp_err_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) preload(16'h4000 + 16'(i), 8'($urandom_range(0, 255)));
    t = done_cnt + 1;
    issue(16'h4000, 16'h5000, 16'd4, 1'b0, 8'h0, 1'b0);
    wait_done(t, 60);

    // Randomized copies, one with a start pulse while busy
    for (int r = 0; r < 8; r++) begin
      s = 16'($urandom_range(0, 65535));
      d = 16'($urandom_range(0, 65535));
      n = 16'($urandom_range(1, 10));
      for (int i = 0; i < int'(n); i++) preload(s + 16'(i), 8'($urandom_range(0, 255)));
      t = done_cnt + 1;
      issue(s, d, n, 1'b0, 8'h0, 1'b0);
      if (r == 3) begin
        @(negedge clk);
        src_addr = 16'h0000; dst_addr = 16'h0010; len = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done(t, 4 * int'(n) + 40);
    end

`ifdef BRAM_DMA_FILL_EN
    t = done_cnt + 1;
    issue(16'h0000, 16'h3000, 16'd5, 1'b1, 8'hA5, 1'b0);
    wait_done(t, 40);
    for (int i = 0; i < 5; i++) check("fill_mem", {24'h0, mem[16'h3000 + 16'(i)]}, 32'hA5);
`endif

    repeat (3) @(negedge clk);
    check("final_done_count", exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
